// File: rtl/elevator_pkg.sv
// Shared types and sizing for the hall-call request front end of the dual elevator system.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);

    typedef logic [FLOOR_W-1:0]    floor_t;
    typedef logic [NUM_FLOORS-1:0] floor_vec_t;

    typedef enum logic {
        NORMAL = 1'b0,
        ESTOP  = 1'b1
    } panel_state_t;

    // One-hot floor vector for a car that is standing at a floor with its door open.
    function automatic floor_vec_t served_floors(floor_t car_floor, logic door_open);
        floor_vec_t v;
        v = '0;
        if (door_open) begin
            v[car_floor] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/hall_call_panel_if.sv
// Request/acknowledge link between the hall call panel (master) and the dispatcher (slave).
interface hall_call_panel_if;
    import elevator_pkg::*;

    floor_vec_t floor_requests;
    floor_vec_t request_ack;
    logic       emergency_stop;
    logic       priority_request;
    floor_t     priority_floor;

    modport master (
        output floor_requests,
        output emergency_stop,
        output priority_request,
        output priority_floor,
        input  request_ack
    );

    modport slave (
        input  floor_requests,
        input  emergency_stop,
        input  priority_request,
        input  priority_floor,
        output request_ack
    );

endinterface

// File: rtl/hall_call_panel_sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer with a registered
// rise pulse that is high for the first cycle of a new high level.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/hall_call_panel.sv
// Hall call panel: debounces hall buttons, estop and fireman key, tracks per-floor calls
// through the request/ack handshake, and drives call lamps and stale-call flags.
module hall_call_panel
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STALE_CYCLES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  floor_vec_t btn_raw,
    input  logic       estop_btn,
    input  logic       estop_reset,
    input  logic       key_on,
    input  floor_t     key_floor,
    input  floor_t     elev1_current_floor,
    input  logic       elev1_door_open,
    input  floor_t     elev2_current_floor,
    input  logic       elev2_door_open,
    output floor_vec_t call_lamp,
    output floor_vec_t stale_call,
    hall_call_panel_if.master disp
);

    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    floor_vec_t btn_level, btn_rise;
    logic       estop_level, estop_rise;
    logic       key_level, key_rise;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
        sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (btn_raw[f]),
            .level_o (btn_level[f]),
            .rise_o  (btn_rise[f])
        );
    end

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_estop (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (estop_btn),
        .level_o (estop_level),
        .rise_o  (estop_rise)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (key_on),
        .level_o (key_level),
        .rise_o  (key_rise)
    );

    logic         erst_sync1_q, erst_sync2_q;
    floor_t       kf_sync1_q, kf_sync2_q;
    floor_t       prio_floor_q, prio_floor_d;
    panel_state_t state_q, state_d;
    logic         enter_estop;
    floor_vec_t   pending_q, pending_d;
    floor_vec_t   acked_q, acked_d;
    floor_vec_t   serve, mask, ack_hit;
    logic [STALE_W-1:0] stale_cnt_q [NUM_FLOORS];
    logic [STALE_W-1:0] stale_cnt_d [NUM_FLOORS];

    always_comb begin
        state_d     = state_q;
        enter_estop = 1'b0;
        case (state_q)
            NORMAL: begin
                if (estop_rise) begin
                    state_d     = ESTOP;
                    enter_estop = 1'b1;
                end
            end
            ESTOP: begin
                if (erst_sync2_q && !estop_level) begin
                    state_d = NORMAL;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // The key floor is forwarded during the rise cycle so the mask is right from the start.
    assign prio_floor_d = key_rise ? kf_sync2_q : prio_floor_q;

    assign serve   = served_floors(elev1_current_floor, elev1_door_open)
                   | served_floors(elev2_current_floor, elev2_door_open);
    assign ack_hit = disp.request_ack & pending_q;

    always_comb begin
        pending_d = pending_q;
        acked_d   = acked_q;
        mask      = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            stale_cnt_d[f] = stale_cnt_q[f];
            mask[f] = key_level && (floor_t'(f) != prio_floor_d);

            // Clearing wins over setting, and setting over acknowledging.
            if (enter_estop || serve[f]) begin
                pending_d[f] = 1'b0;
                acked_d[f]   = 1'b0;
            end else if (btn_rise[f] && state_q == NORMAL) begin
                pending_d[f] = 1'b1;
                acked_d[f]   = 1'b0;
            end else if (ack_hit[f]) begin
                acked_d[f] = 1'b1;
            end

            if (enter_estop || serve[f] || ack_hit[f]) begin
                stale_cnt_d[f] = '0;
            end else if (pending_q[f] && !acked_q[f] && state_q == NORMAL &&
                         stale_cnt_q[f] != STALE_W'(STALE_CYCLES)) begin
                stale_cnt_d[f] = stale_cnt_q[f] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            erst_sync1_q <= 1'b0;
            erst_sync2_q <= 1'b0;
            kf_sync1_q   <= '0;
            kf_sync2_q   <= '0;
            prio_floor_q <= '0;
            state_q      <= NORMAL;
            pending_q    <= '0;
            acked_q      <= '0;
            // NOTE: the timer array is small control state, not storage, so every entry is reset explicitly.
            for (int f = 0; f < NUM_FLOORS; f++) begin
                stale_cnt_q[f] <= '0;
            end
        end else begin
            erst_sync1_q <= estop_reset;
            erst_sync2_q <= erst_sync1_q;
            kf_sync1_q   <= key_floor;
            kf_sync2_q   <= kf_sync1_q;
            prio_floor_q <= prio_floor_d;
            state_q      <= state_d;
            pending_q    <= pending_d;
            acked_q      <= acked_d;
            for (int f = 0; f < NUM_FLOORS; f++) begin
                stale_cnt_q[f] <= stale_cnt_d[f];
            end
        end
    end

    assign disp.emergency_stop   = (state_q == ESTOP);
    assign disp.priority_request = key_level;
    assign disp.priority_floor   = prio_floor_d;
    assign disp.floor_requests   = pending_q & ~acked_q & ~mask
                                 & {NUM_FLOORS{state_q == NORMAL}};
    assign call_lamp = pending_q;

    always_comb begin
        stale_call = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            stale_call[f] = (stale_cnt_q[f] == STALE_W'(STALE_CYCLES));
        end
    end

endmodule
